fc_stream_layer: RTL and testbench

//  Fully-connected layer placed directly downstream of cnn_block. It consumes the pooled Q-format

---
 rtl/fc_stream_layer.sv | 139 +++++++++++++
 tb/tb_fc_stream_layer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_stream_layer.sv
// Fully-connected layer: streams IN_LEN samples into OUT_LEN parallel MACs, then drains
// OUT_LEN biased, saturated (optionally ReLU'd) results one per cycle.
module fc_stream_layer #(
    parameter int unsigned N       = 16,
    parameter int unsigned Q       = 12,
    parameter int unsigned IN_LEN  = 4,
    parameter int unsigned OUT_LEN = 2,
    parameter int unsigned RELU    = 1
) (
    input  logic                clk,
    input  logic                global_rst,
    input  logic                ce,
    input  logic signed [N-1:0] data_in,
    input  logic                valid_in,
    input  logic                end_in,
    output logic                in_ready,
    input  logic                w_we,
    input  logic [7:0]          w_addr,
    input  logic [N-1:0]        w_data,
    output logic signed [N-1:0] data_out,
    output logic                valid_op,
    output logic                end_op,
    output logic                overflow
);

    localparam int unsigned CNT_W = $clog2(IN_LEN) + 1;
    localparam int unsigned ACC_W = 2 * N + $clog2(IN_LEN) + 1;
    localparam int unsigned NW    = IN_LEN * OUT_LEN;
    localparam int unsigned NWB   = NW + OUT_LEN;
    localparam int unsigned A_W   = $clog2(NWB);
    localparam int unsigned J_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

    localparam logic signed [ACC_W:0] MAX_V = (ACC_W + 1)'((2 ** (N - 1)) - 1);
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

    state_t                    state, state_next;
    logic [CNT_W-1:0]          count;
    logic [J_W-1:0]            out_idx;
    logic signed [N-1:0]       wram [NWB];
    logic signed [ACC_W-1:0]   acc  [OUT_LEN];
    logic signed [2*N-1:0]     prod [OUT_LEN];
    logic                      accept, drain_step, last_out;
    logic signed [ACC_W:0]     sum, shifted;
    logic signed [N-1:0]       result;

    // Weight/bias RAM survives reset; writable only while idle
    always_ff @(posedge clk) begin
        if (w_we && state == IDLE && w_addr < 8'(NWB))
            wram[w_addr[A_W-1:0]] <= w_data;
    end

    // count is 0 in IDLE, so the same index serves the first sample
    always_comb begin
        for (int j = 0; j < OUT_LEN; j++)
            prod[j] = data_in * wram[A_W'(j * IN_LEN + int'(count))];
    end

    // Bias is aligned to the product's Q2 scale before the arithmetic shift
    always_comb begin
        sum     = (ACC_W + 1)'(acc[out_idx])
                + ((ACC_W + 1)'(wram[A_W'(NW + int'(out_idx))]) <<< Q);
        shifted = sum >>> Q;
        if (shifted > MAX_V)
            result = N'(MAX_V);
        else if (shifted < MIN_V)
            result = N'(MIN_V);
        else
            result = N'(shifted);
        if (RELU != 0 && result[N-1])
            result = '0;
    end

    always_ff @(posedge clk) begin
        if (global_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drain_step = 1'b0;
        last_out   = (out_idx == J_W'(OUT_LEN - 1));
        case (state)
            IDLE, ACC: begin
                if (ce && valid_in) begin
                    accept = 1'b1;
                    if (end_in || int'(count) == int'(IN_LEN) - 1)
                        state_next = DRAIN;
                    else
                        state_next = ACC;
                end
            end
            DRAIN: begin
                if (ce) begin
                    drain_step = 1'b1;
                    if (last_out)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            count    <= '0;
            out_idx  <= '0;
            data_out <= '0;
            valid_op <= 1'b0;
            end_op   <= 1'b0;
            overflow <= 1'b0;
            in_ready <= 1'b1;
            for (int j = 0; j < OUT_LEN; j++)
                acc[j] <= '0;
        end else begin
            valid_op <= 1'b0;
            end_op   <= 1'b0;
            in_ready <= (state_next != DRAIN);
            if (ce && valid_in && state == DRAIN)
                overflow <= 1'b1;
            if (accept) begin
                for (int j = 0; j < OUT_LEN; j++)
                    acc[j] <= (state == IDLE) ? ACC_W'(prod[j]) : acc[j] + ACC_W'(prod[j]);
                count <= (state_next == DRAIN) ? '0 : count + 1'b1;
            end
            if (drain_step) begin
                data_out <= result;
                valid_op <= 1'b1;
                end_op   <= last_out;
                out_idx  <= last_out ? '0 : out_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fc_stream_layer.sv
// Directed bench for fc_stream_layer: a ReLU and a linear instance share stimulus;
// expected results are queued at stimulus time and popped as outputs appear.
module tb_fc_stream_layer;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } exp_t;

    logic        clk, global_rst, ce, valid_in, end_in, w_we;
    logic [15:0] data_in, w_data;
    logic [7:0]  w_addr;
    logic [15:0] do1, do0;
    logic        vo1, vo0, eo1, eo0, ov1, ov0, ir1, ir0;

    exp_t q_relu[$];
    exp_t q_lin[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    fc_stream_layer #(.RELU(1)) u_relu (
        .clk(clk), .global_rst(global_rst), .ce(ce), .data_in(data_in),
        .valid_in(valid_in), .end_in(end_in), .in_ready(ir1), .w_we(w_we),
        .w_addr(w_addr), .w_data(w_data), .data_out(do1), .valid_op(vo1),
        .end_op(eo1), .overflow(ov1)
    );

    fc_stream_layer #(.RELU(0)) u_lin (
        .clk(clk), .global_rst(global_rst), .ce(ce), .data_in(data_in),
        .valid_in(valid_in), .end_in(end_in), .in_ready(ir0), .w_we(w_we),
        .w_addr(w_addr), .w_data(w_data), .data_out(do0), .valid_op(vo0),
        .end_op(eo0), .overflow(ov0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Scoreboard drain: compare every produced result against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (vo1 === 1'b1) begin
            if (q_relu.size() == 0) chk("relu_unexpected_valid", 32'(vo1), 0);
            else begin
                e = q_relu.pop_front();
                chk("relu_data", 32'(do1), 32'(e.d));
                chk("relu_end", 32'(eo1), 32'(e.e));
            end
        end
        if (vo0 === 1'b1) begin
            if (q_lin.size() == 0) chk("lin_unexpected_valid", 32'(vo0), 0);
            else begin
                e = q_lin.pop_front();
                chk("lin_data", 32'(do0), 32'(e.d));
                chk("lin_end", 32'(eo0), 32'(e.e));
            end
        end
    end

    task automatic drive(input logic [15:0] x, input logic v, input logic e, input logic c);
        data_in = x; valid_in = v; end_in = e; ce = c;
        @(negedge clk);
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) drive(16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        w_we = 1'b1; w_addr = a; w_data = d;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic set_w(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] b0, input logic [15:0] b1);
        for (int i = 0; i < 4; i++) wr(8'(i), w0);
        for (int i = 0; i < 4; i++) wr(8'(4 + i), w1);
        wr(8'd8, b0);
        wr(8'd9, b1);
    endtask

    task automatic expect_frame(input logic [15:0] r0, input logic [15:0] r1,
                                input logic [15:0] l0, input logic [15:0] l1);
        q_relu.push_back(exp_t'{d: r0, e: 1'b0});
        q_relu.push_back(exp_t'{d: r1, e: 1'b1});
        q_lin.push_back(exp_t'{d: l0, e: 1'b0});
        q_lin.push_back(exp_t'{d: l1, e: 1'b1});
    endtask

    task automatic send(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                        input logic [15:0] x3, input int n, input logic fin);
        logic [15:0] xs [4];
        xs = '{x0, x1, x2, x3};
        for (int i = 0; i < n; i++) drive(xs[i], 1'b1, fin && (i == n - 1), 1'b1);
        valid_in = 1'b0; end_in = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && (q_relu.size() != 0 || q_lin.size() != 0); k++)
            @(negedge clk);
        chk("drain_done", 32'(q_relu.size() + q_lin.size()), 0);
    endtask

    initial begin
        global_rst = 1'b1; ce = 1'b1; valid_in = 1'b0; end_in = 1'b0;
        data_in = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_data_out", 32'(do1), 0);
        chk("rst_valid_op", 32'(vo1), 0);
        chk("rst_end_op", 32'(eo1), 0);
        chk("rst_overflow", 32'(ov1), 0);
        chk("rst_in_ready", 32'(ir1), 1);
        global_rst = 1'b0;

        // Unity weights, full frame, with latency checks
        set_w(16'h1000, 16'h1000, 16'h0000, 16'h0000);
        expect_frame(16'h1E00, 16'h1E00, 16'h1E00, 16'h1E00);
        send(16'h1000, 16'h0800, 16'h0400, 16'h0200, 4, 1'b1);
        chk("t1_no_valid_at_E", 32'(vo1), 0);
        chk("t1_busy_at_E", 32'(ir1), 0);
        @(negedge clk);
        chk("t1_first_valid", 32'(vo1), 1);
        chk("t1_first_not_end", 32'(eo1), 0);
        @(negedge clk);
        chk("t1_last_end", 32'(eo1), 1);
        chk("t1_ready_again", 32'(ir1), 1);
        wait_drain();
        chk("t1_no_overflow", 32'(ov1), 0);

        // Bias on neuron 0, negative weight on neuron 1
        set_w(16'h1000, 16'hF000, 16'h0800, 16'h0000);
        expect_frame(16'h2600, 16'h0000, 16'h2600, 16'hE200);
        send(16'h1000, 16'h0800, 16'h0400, 16'h0200, 4, 1'b1);
        wait_drain();

        // Saturation on both rails
        set_w(16'h7FFF, 16'h8000, 16'h0000, 16'h0000);
        expect_frame(16'h7FFF, 16'h0000, 16'h7FFF, 16'h8000);
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4, 1'b1);
        wait_drain();

        // Early end, then a back-to-back full frame
        set_w(16'h1000, 16'h1000, 16'h0000, 16'h0000);
        expect_frame(16'h2000, 16'h2000, 16'h2000, 16'h2000);
        send(16'h1000, 16'h1000, 16'h0000, 16'h0000, 2, 1'b1);
        idle_cyc(2);
        expect_frame(16'h1E00, 16'h1E00, 16'h1E00, 16'h1E00);
        send(16'h1000, 16'h0800, 16'h0400, 16'h0200, 4, 1'b1);
        wait_drain();

        // Reset mid-frame: aborted frame must produce nothing, weights retained
        send(16'h1000, 16'h0800, 16'h0000, 16'h0000, 2, 1'b0);
        global_rst = 1'b1;
        @(negedge clk);
        global_rst = 1'b0;
        chk("t5_ready_after_rst", 32'(ir1), 1);
        idle_cyc(3);
        expect_frame(16'h1E00, 16'h1E00, 16'h1E00, 16'h1E00);
        send(16'h1000, 16'h0800, 16'h0400, 16'h0200, 4, 1'b1);
        wait_drain();

        // ce=0 stalls mid-frame; sample offered during drain is dropped and flagged
        expect_frame(16'h1E00, 16'h1E00, 16'h1E00, 16'h1E00);
        drive(16'h1000, 1'b1, 1'b0, 1'b1);
        drive(16'h0800, 1'b1, 1'b0, 1'b1);
        repeat (3) drive(16'h7FFF, 1'b1, 1'b0, 1'b0);
        chk("t6_ce0_no_overflow", 32'(ov1), 0);
        drive(16'h0400, 1'b1, 1'b0, 1'b1);
        drive(16'h0200, 1'b1, 1'b1, 1'b1);
        drive(16'h7FFF, 1'b1, 1'b0, 1'b1);
        valid_in = 1'b0;
        chk("t6_overflow_set", 32'(ov1), 1);
        chk("t6_overflow_set_lin", 32'(ov0), 1);
        wait_drain();
        idle_cyc(5);
        chk("t6_overflow_sticky", 32'(ov1), 1);
        global_rst = 1'b1;
        @(negedge clk);
        global_rst = 1'b0;
        chk("t6_overflow_cleared", 32'(ov1), 0);

        // ce=0 during drain suppresses valid_op and holds the frame
        expect_frame(16'h1E00, 16'h1E00, 16'h1E00, 16'h1E00);
        send(16'h1000, 16'h0800, 16'h0400, 16'h0200, 4, 1'b1);
        drive(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("t7_ce0_no_valid", 32'(vo1), 0);
        chk("t7_ce0_still_busy", 32'(ir1), 0);
        ce = 1'b1;
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
